vga_pixel_fetch: RTL
====================

# vga_pixel_fetch

- Upstream feeder for `vga_control`.
- Prefetches pixels in raster order from a word-per-pixel RGB565 frame buffer through a request/grant/valid memory port.
- Buffers pixels in a small FIFO and expands each one to 8-bit RGB.
- Presents the expanded pixel on `VGA_R_OUT/G_OUT/B_OUT`, which drive `vga_control`'s `VGA_R_IN/G_IN/B_IN`, one pixel per `REQUEST_DATA` pulse.

## Interface

- `DEPTH`, 16: FIFO entries. Power of two, ≥ 4.
- `H_RES`, 640: visible pixels per line.
- `V_RES`, 480: visible lines per frame.
- `ADDR_W`, 19: frame-buffer word address width. Must hold `H_RES*V_RES-1`.

Ports:

- `VGA_CLK` in 1: pixel clock. All logic on rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `VGA_VS` in 1: vertical sync from `vga_control`, active low. A falling edge marks frame restart.
- `REQUEST_DATA` in 1: pop one pixel. Data is required on the following cycle.
- `MEM_REQ` out 1: read request.
- `MEM_ADDR` out ADDR_W: read address, valid while `MEM_REQ`.
- `MEM_GNT` in 1: request accepted this cycle.
- `MEM_RVALID` in 1: read data returned, in request order.
- `MEM_RDATA` in 16: RGB565, with R=[15:11], G=[10:5], B=[4:0].
- `VGA_R_OUT`, `VGA_G_OUT`, `VGA_B_OUT` out 8 each: current pixel.
- `UNDERFLOW` out 1: sticky flag, set when a pop hits an empty FIFO.

## Operation

- **Credits:** `outstanding` = granted reads not yet returned, width `$clog2(DEPTH+1)`.
  - `MEM_REQ` = (state==FETCH) && (`count` + `outstanding` < DEPTH) && (`addr` < H_RES*V_RES).
  - FIFO overflow is therefore impossible.
  - A grant increments `addr` and `outstanding`. `RVALID` decrements `outstanding`.
- **FSM states:**
  - **FETCH:** issue requests. RVALID data is written to the FIFO. Moves to DONE when `addr` == H_RES*V_RES and `outstanding` == 0.
  - **DONE:** no requests. Pops continue until the FIFO is empty.
  - **FLUSH:**
    - Entered from any state on a `VGA_VS` falling edge, detected via a registered copy of `VGA_VS`.
    - On entry: FIFO cleared, `addr` set to 0.
    - `MEM_REQ` is held low. RVALID data is discarded and still decrements `outstanding`.
    - Moves to FETCH when `outstanding` == 0 (may be the next cycle).
- **Pop:**
  - `REQUEST_DATA` with `count` > 0: head is read and the expanded value is registered onto the outputs.
  - `REQUEST_DATA` with `count` == 0: outputs are loaded with 0, `UNDERFLOW` is set.
  - Without `REQUEST_DATA`, outputs hold.
- **Expansion:** R = {r5, r5[4:2]}; G = {g6, g6[5:4]}; B = {b5, b5[4:2]}.
- **Simultaneous events:**
  - RVALID write and pop in the same cycle, `count` > 0: `count` unchanged.
  - RVALID write and pop in the same cycle, `count` == 0: no bypass; this is an underflow.
  - VS edge together with GNT: the grant is counted into `outstanding` and its data discarded in FLUSH.
  - VS edge together with RVALID: the data is discarded.
  - VS edge together with a pop: the pop completes from the pre-clear FIFO.
- **`UNDERFLOW`:** cleared only by reset.

## Timing

- **Reset values:**
  - State = FETCH, `addr` = 0, `count` = 0, `outstanding` = 0.
  - `MEM_REQ` = 0 during reset.
  - RGB outputs = 0, `UNDERFLOW` = 0, VS register = 1.
- **First request:** `MEM_REQ` asserts in the first cycle after reset release.
- **Pop latency:** 1 cycle. `REQUEST_DATA` at cycle n gives the pixel on the outputs at n+1.
- **Memory latency:** any. Minimum 1 cycle from grant to RVALID.
- **Throughput:** one request per cycle when granted.
- **VS edge:** a falling edge sampled at cycle n enters FLUSH at n+1. `MEM_REQ` is low from n+1.

## Structure

- Package `vga_pkg` holds:
  - `H_RES`/`V_RES` defaults.
  - `typedef struct packed {logic [4:0] r; logic [5:0] g; logic [4:0] b;} rgb565_t`.
  - State enum `fetch_state_t` {FETCH, DONE, FLUSH}.
  - Expansion function `rgb565_to_888`.
- Sub-module `pixel_fifo`:
  - Synchronous FIFO, `DEPTH`×16, with `wr_en`/`rd_en`/`clear`.
  - `count` output.
  - Show-ahead head data.

## Test plan

- **Reset then steady fill:** reset, `MEM_GNT`=1, 2-cycle RVALID latency, no pops → exactly 16 grants at addresses 0..15, then `MEM_REQ` low; `count`=16.
- **Pop and expand:** pop word 0xF800 → next cycle R=0xFF, G=0x00, B=0x00. Pop 0x07E0 → G=0xFF. Pop 0x8410 → R=0x84, G=0x82, B=0x84.
- **Underflow:** `MEM_GNT`=0, pulse `REQUEST_DATA` → outputs 0 next cycle, `UNDERFLOW`=1. It stays 1 after data arrives.
- **Frame end:** H_RES=4, V_RES=2, continuous pops → addresses 0..7 only, state DONE, no request at address 8.
- **Mid-frame VS:** VS falls with 3 reads outstanding → the 3 RVALIDs are discarded, `count`=0, then the next request address is 0.
- **Back-pressure:** `MEM_GNT` toggling 1/0 with pop every cycle → returned pixels in address order; no address skipped or repeated.

Source files
------------

// File: rtl/vga_pixel_fetch_pkg.sv
// vga_pkg: shared types, defaults and RGB565 -> RGB888 expansion for vga_pixel_fetch.
// No ports; imported by the FIFO and the top level.
package vga_pkg;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;
    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;
    typedef enum logic [1:0] {FETCH, DONE, FLUSH} fetch_state_t;
    // Replicating the top bits into the new LSBs maps full-scale to 0xFF and zero to 0x00.
    function automatic logic [23:0] rgb565_to_888(rgb565_t p);
        return {p.r, p.r[4:2], p.g, p.g[5:4], p.b, p.b[4:2]};
    endfunction
endpackage

// File: rtl/vga_pixel_fetch_if.sv
// vga_pixel_fetch_if: request/grant/valid read port to the frame buffer.
// req/addr from the fetcher; gnt accepts a request, rvalid/rdata return data in request order.
interface vga_pixel_fetch_if #(parameter int ADDR_W = 19);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic              rvalid;
    logic [15:0]       rdata;
    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/vga_pixel_fetch_fifo.sv
// pixel_fifo: show-ahead synchronous FIFO of RGB565 pixels.
// clk/rst_n, clear empties it, wr_en/wr_data push, rd_en pops when not empty,
// rd_data is the current head, count is the fill level.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       wr_en,
    input  rgb565_t                    wr_data,
    input  logic                       rd_en,
    output rgb565_t                    rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    rgb565_t ram [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic rd;
    // Writes are never blocked: the fetcher's credit scheme guarantees room.
    assign rd = rd_en && count != '0;
    assign rd_data = ram[rd_ptr];
    always_ff @(posedge clk) begin
        if (wr_en && !clear) ram[wr_ptr] <= wr_data;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(wr_en) - CW'(rd);
        end
    end
endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: prefetches a raster-order RGB565 frame into a FIFO and pops
// expanded RGB888 pixels for vga_control.
// VGA_CLK/RESET_N clock and async active-low reset; VGA_VS falling edge restarts the frame;
// REQUEST_DATA pops one pixel onto VGA_R/G/B_OUT next cycle; mem is the frame-buffer read port;
// UNDERFLOW is sticky when a pop finds the FIFO empty.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF,
    parameter int ADDR_W = 19
) (
    input  logic                    VGA_CLK,
    input  logic                    RESET_N,
    input  logic                    VGA_VS,
    input  logic                    REQUEST_DATA,
    vga_pixel_fetch_if.master       mem,
    output logic [7:0]              VGA_R_OUT,
    output logic [7:0]              VGA_G_OUT,
    output logic [7:0]              VGA_B_OUT,
    output logic                    UNDERFLOW
);
    localparam int CW = $clog2(DEPTH + 1);
    // One extra bit so the address can sit at one-past-the-end after the last grant.
    localparam logic [ADDR_W:0] TOTAL = (ADDR_W+1)'(H_RES * V_RES);
    fetch_state_t state;
    logic [ADDR_W:0] addr;
    logic [CW-1:0] outstanding, count;
    logic vs_q, vs_fall, grant, wr_en;
    rgb565_t head;
    assign vs_fall = vs_q && !VGA_VS;
    // Credits cover both buffered and in-flight pixels, so the FIFO can never overflow.
    assign mem.req = RESET_N && state == FETCH && addr < TOTAL
                     && ({1'b0, count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
    assign mem.addr = addr[ADDR_W-1:0];
    assign grant = mem.req && mem.gnt;
    // Returns during FLUSH, or in the edge cycle itself, belong to the abandoned frame.
    assign wr_en = mem.rvalid && state == FETCH && !vs_fall;
    pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (VGA_CLK),
        .rst_n   (RESET_N),
        .clear   (vs_fall),
        .wr_en   (wr_en),
        .wr_data (mem.rdata),
        .rd_en   (REQUEST_DATA),
        .rd_data (head),
        .count   (count)
    );
    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= FETCH;
            addr        <= '0;
            outstanding <= '0;
            vs_q        <= 1'b1;
            VGA_R_OUT   <= '0;
            VGA_G_OUT   <= '0;
            VGA_B_OUT   <= '0;
            UNDERFLOW   <= 1'b0;
        end else begin
            vs_q        <= VGA_VS;
            outstanding <= outstanding + CW'(grant) - CW'(mem.rvalid);
            if (vs_fall) begin
                state <= FLUSH;
                addr  <= '0;
            end else begin
                if (grant) addr <= addr + (ADDR_W+1)'(1);
                state <= (state == FETCH && addr == TOTAL && outstanding == '0) ? DONE :
                         (state == FLUSH && outstanding == '0) ? FETCH : state;
            end
            // The pop sees the pre-clear FIFO even when a VS edge clears it this cycle.
            if (REQUEST_DATA) begin
                {VGA_R_OUT, VGA_G_OUT, VGA_B_OUT} <= (count != '0) ? rgb565_to_888(head) : 24'h0;
                UNDERFLOW <= UNDERFLOW || count == '0;
            end
        end
    end
endmodule
